// File: rtl/emu_host_ctrl.sv
// emu_host_ctrl: toggle-handshake host command sequencer driving one ready/valid transfer per command
// Ports:
//   clock, reset                    single clock, synchronous active-high reset
//   host_cmd_toggle/op/wdata0/1     host command (any toggle level change = one command)
//   host_err_clr                    level, clears sticky errors
//   host_ack_toggle, host_rdata     completion toggle and io_out captured data
//   host_busy, host_err             in-flight flag, sticky {overrun, timeout, illegal}
//   host_*_cnt, host_stall_cycles   per-port transfer counters, stall-cycle counter
//   io_insns_*, io_io_i_*, io_io_o_* emulator ready/valid ports
// Option: define EMU_HOST_CTRL_PERF_EN to build the stall-cycle counter.
module emu_host_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             host_cmd_toggle,
  input  logic [1:0]       host_cmd_op,
  input  logic [15:0]      host_wdata0,
  input  logic [15:0]      host_wdata1,
  input  logic             host_err_clr,
  output logic             host_ack_toggle,
  output logic [15:0]      host_rdata,
  output logic             host_busy,
  output logic [2:0]       host_err,
  output logic [CNT_W-1:0] host_insn_cnt,
  output logic [CNT_W-1:0] host_in_cnt,
  output logic [CNT_W-1:0] host_out_cnt,
  output logic [31:0]      host_stall_cycles,
  output logic             io_insns_valid,
  input  logic             io_insns_ready,
  output logic [15:0]      io_insns_bits_0,
  output logic [15:0]      io_insns_bits_1,
  output logic             io_io_i_valid,
  input  logic             io_io_i_ready,
  output logic [15:0]      io_io_i_bits_0,
  input  logic             io_io_o_valid,
  output logic             io_io_o_ready,
  input  logic [15:0]      io_io_o_bits_0
);
  typedef enum logic [1:0] {S_IDLE, S_INSN, S_IN, S_OUT} state_t;
  localparam bit TMO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
  state_t r_state, w_next;
  logic r_tog_q, r_ins_v, r_in_v, r_out_r, r_ack;
  logic [15:0] r_w0, r_w1, r_rdata;
  logic [31:0] r_tmo;
  logic [2:0] r_err;
  logic [CNT_W-1:0] r_insn_cnt, r_in_cnt, r_out_cnt;
  logic w_cmd, w_busy, w_hs_insn, w_hs_in, w_hs_out, w_hs, w_tmo, w_done, w_ill, w_ovr;
  assign w_cmd = host_cmd_toggle != r_tog_q;
  assign w_busy = r_state != S_IDLE;
  assign w_hs_insn = r_ins_v & io_insns_ready;
  assign w_hs_in = r_in_v & io_io_i_ready;
  assign w_hs_out = r_out_r & io_io_o_valid;
  assign w_hs = w_hs_insn | w_hs_in | w_hs_out;
  // r_tmo counts completed waiting cycles, so the abort lands on the TIMEOUT_CYCLES-th busy cycle
  assign w_tmo = TMO_EN && w_busy && !w_hs && r_tmo == TMO_LAST;
  assign w_done = w_busy & (w_hs | w_tmo);
  assign w_ill = !w_busy && w_cmd && host_cmd_op == 2'd3;
  assign w_ovr = w_busy & w_cmd;
  always_comb begin
    w_next = r_state;
    if (w_done) w_next = S_IDLE;
    // ops 0,1,2 map onto INSN, IN, OUT in encoding order
    else if (!w_busy && w_cmd && host_cmd_op != 2'd3) w_next = state_t'(host_cmd_op + 2'd1);
  end
  always_ff @(posedge clock) begin
    r_tog_q <= host_cmd_toggle;
    if (reset) begin
      r_state <= S_IDLE;
      r_ins_v <= 1'b0;
      r_in_v <= 1'b0;
      r_out_r <= 1'b0;
      r_tmo <= '0;
      r_w0 <= '0;
      r_w1 <= '0;
      r_ack <= 1'b0;
      r_rdata <= '0;
      r_err <= '0;
      r_insn_cnt <= '0;
      r_in_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_ins_v <= w_next == S_INSN;
      r_in_v <= w_next == S_IN;
      r_out_r <= w_next == S_OUT;
      r_tmo <= (TMO_EN && w_busy && !w_done) ? r_tmo + 32'd1 : '0;
      if (!w_busy && w_cmd) begin
        r_w0 <= host_wdata0;
        r_w1 <= host_wdata1;
      end
      if (w_ill || w_done) r_ack <= ~r_ack;
      if (w_hs_out) r_rdata <= io_io_o_bits_0;
      if (w_hs_insn) r_insn_cnt <= r_insn_cnt + CNT_W'(1);
      if (w_hs_in) r_in_cnt <= r_in_cnt + CNT_W'(1);
      if (w_hs_out) r_out_cnt <= r_out_cnt + CNT_W'(1);
      // a set event in the clear cycle still lands
      r_err <= (host_err_clr ? 3'b000 : r_err) | {w_ovr, w_tmo, w_ill};
    end
  end
`ifdef EMU_HOST_CTRL_PERF_EN
  logic [31:0] r_stall;
  always_ff @(posedge clock) begin
    if (reset || host_err_clr) r_stall <= '0;
    else if (w_busy && !w_hs && r_stall != '1) r_stall <= r_stall + 32'd1;
  end
  assign host_stall_cycles = r_stall;
`else
  assign host_stall_cycles = '0;
`endif
  assign host_ack_toggle = r_ack;
  assign host_rdata = r_rdata;
  assign host_busy = w_busy;
  assign host_err = r_err;
  assign host_insn_cnt = r_insn_cnt;
  assign host_in_cnt = r_in_cnt;
  assign host_out_cnt = r_out_cnt;
  assign io_insns_valid = r_ins_v;
  assign io_insns_bits_0 = r_w0;
  assign io_insns_bits_1 = r_w1;
  assign io_io_i_valid = r_in_v;
  assign io_io_i_bits_0 = r_w0;
  assign io_io_o_ready = r_out_r;
endmodule

// File: tb/tb_emu_host_ctrl.sv
// tb_emu_host_ctrl: directed and randomized check of emu_host_ctrl against a transaction-level model
module tb_emu_host_ctrl;
  localparam int TMO = 8;
  localparam int CW = 4;
  logic clock = 0, reset = 1, tog = 0, clr = 0;
  logic [1:0] op = 0;
  logic [15:0] w0 = 0, w1 = 0, o_bits = 0;
  logic insns_ready = 0, i_ready = 0, o_valid = 0;
  logic ack, busy, insns_valid, i_valid, o_ready;
  logic [15:0] rdata, ib0, ib1, iib0;
  logic [2:0] err;
  logic [CW-1:0] c_insn, c_in, c_out;
  logic [31:0] stall;
  emu_host_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .host_cmd_toggle(tog), .host_cmd_op(op),
    .host_wdata0(w0), .host_wdata1(w1), .host_err_clr(clr),
    .host_ack_toggle(ack), .host_rdata(rdata), .host_busy(busy), .host_err(err),
    .host_insn_cnt(c_insn), .host_in_cnt(c_in), .host_out_cnt(c_out), .host_stall_cycles(stall),
    .io_insns_valid(insns_valid), .io_insns_ready(insns_ready), .io_insns_bits_0(ib0), .io_insns_bits_1(ib1),
    .io_io_i_valid(i_valid), .io_io_i_ready(i_ready), .io_io_i_bits_0(iib0),
    .io_io_o_valid(o_valid), .io_io_o_ready(o_ready), .io_io_o_bits_0(o_bits)
  );
  always #5 clock = ~clock;
  int errors = 0, checks = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Model: one pending command with its age; everything else is plain bookkeeping.
  bit m_init = 0, m_tq = 0, m_pend = 0, m_ack = 0;
  int m_op = 0, m_age = 0;
  int m_cnt[3] = '{0, 0, 0};
  logic [15:0] m_w0 = 0, m_w1 = 0, m_rdata = 0;
  logic [2:0] m_err = 0;
  longint m_stall = 0;
  task automatic model_step();
    bit cmd, hs, ov, to, il, st;
    cmd = tog != m_tq;
    ov = 0; to = 0; il = 0; st = 0;
    if (reset) begin
      m_pend = 0; m_ack = 0; m_rdata = 0; m_err = 0; m_stall = 0;
      m_cnt = '{0, 0, 0};
      m_init = 1;
    end else begin
      if (m_pend) begin
        hs = m_op == 0 ? insns_ready : m_op == 1 ? i_ready : o_valid;
        if (!hs) begin
          m_age++;
          st = 1;
        end
        if (hs) begin
          m_cnt[m_op]++;
          if (m_op == 2) m_rdata = o_bits;
          m_ack = !m_ack;
          m_pend = 0;
        end else if (TMO != 0 && m_age == TMO) begin
          to = 1;
          m_ack = !m_ack;
          m_pend = 0;
        end
        ov = cmd;
      end else if (cmd) begin
        if (op == 3) begin
          il = 1;
          m_ack = !m_ack;
        end else begin
          m_pend = 1; m_op = int'(op); m_w0 = w0; m_w1 = w1; m_age = 0;
        end
      end
      m_err = (clr ? 3'b000 : m_err) | {ov, to, il};
      if (clr) m_stall = 0;
      else if (st && m_stall < 64'hFFFF_FFFF) m_stall++;
    end
    m_tq = tog;
  endtask
  initial forever begin
    @(posedge clock);
    model_step();
  end
  initial forever begin
    @(negedge clock);
    if (m_init) begin
      chk("busy", busy, m_pend);
      chk("insns_valid", insns_valid, m_pend && m_op == 0);
      chk("io_i_valid", i_valid, m_pend && m_op == 1);
      chk("io_o_ready", o_ready, m_pend && m_op == 2);
      if (m_pend && m_op == 0) begin
        chk("insns_bits_0", ib0, m_w0);
        chk("insns_bits_1", ib1, m_w1);
      end
      if (m_pend && m_op == 1) chk("io_i_bits_0", iib0, m_w0);
      chk("ack", ack, m_ack);
      chk("rdata", rdata, m_rdata);
      chk("err", err, m_err);
      chk("insn_cnt", c_insn, 32'(m_cnt[0] % (1 << CW)));
      chk("in_cnt", c_in, 32'(m_cnt[1] % (1 << CW)));
      chk("out_cnt", c_out, 32'(m_cnt[2] % (1 << CW)));
`ifdef EMU_HOST_CTRL_PERF_EN
      chk("stall", stall, 32'(m_stall));
`else
      chk("stall", stall, 0);
`endif
    end
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  initial begin
    int n, flips, pr;
    logic prev;
    repeat (3) tick();
    reset = 0;
    // insn load with ready already high: 2-cycle latency
    insns_ready = 1; tog = 1; op = 0; w0 = 16'h1234; w1 = 16'hABCD;
    tick();
    @(negedge clock);
    chk("t1_valid", insns_valid, 1);
    chk("t1_bits0", ib0, 16'h1234);
    chk("t1_bits1", ib1, 16'hABCD);
    chk("t1_ack_early", ack, 0);
    tick();
    @(negedge clock);
    chk("t1_valid_drop", insns_valid, 0);
    chk("t1_ack", ack, 1);
    chk("t1_cnt", c_insn, 1);
    insns_ready = 0;
    // io_out with valid arriving on the 6th busy cycle
    tog = 0; op = 2; o_bits = 16'hBEEF; n = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      o_valid = k == 5;
      @(negedge clock);
      n += int'(busy);
    end
    chk("t2_busy_cycles", n, 6);
    chk("t2_rdata", rdata, 16'hBEEF);
    chk("t2_out_cnt", c_out, 1);
    chk("t2_ack", ack, 0);
`ifdef EMU_HOST_CTRL_PERF_EN
    chk("t2_stall", stall, 5);
`else
    chk("t2_stall", stall, 0);
`endif
    // io_in timeout
    tog = 1; op = 1; w0 = 16'h5A5A; n = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      @(negedge clock);
      n += int'(i_valid);
    end
    chk("t3_valid_cycles", n, 8);
    chk("t3_err", err, 3'b010);
    chk("t3_ack", ack, 1);
    chk("t3_in_cnt", c_in, 0);
    // overrun while in IN
    clr = 1;
    tick();
    clr = 0;
    @(negedge clock);
    chk("t4_err_clr", err, 0);
    tog = 0; op = 1; w0 = 16'h0F0F; n = 0; flips = 0; prev = ack;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 2) tog = 1;
      i_ready = k == 5;
      @(negedge clock);
      n += int'(i_valid && i_ready);
      flips += int'(ack != prev);
      prev = ack;
    end
    i_ready = 0;
    chk("t4_transfers", n, 1);
    chk("t4_ack_flips", flips, 1);
    chk("t4_err", err, 3'b100);
    chk("t4_in_cnt", c_in, 1);
    // illegal op, then a one-cycle clear
    clr = 1;
    tick();
    clr = 0; tog = 0; op = 3;
    tick();
    @(negedge clock);
    chk("t5_ack", ack, 1);
    chk("t5_err", err, 3'b001);
    chk("t5_busy", busy, 0);
    chk("t5_port_idle", {insns_valid, i_valid, o_ready}, 0);
    tick();
    clr = 1;
    tick();
    clr = 0;
    @(negedge clock);
    chk("t5_err_clr", err, 0);
    // reset during INSN, toggle held across release
    op = 0; tog = 1; w0 = 16'h7777;
    tick();
    @(negedge clock);
    chk("t6_valid", insns_valid, 1);
    tick();
    reset = 1;
    tick();
    @(negedge clock);
    chk("t6_valid_rst", insns_valid, 0);
    chk("t6_insn_cnt", c_insn, 0);
    chk("t6_out_cnt", c_out, 0);
    chk("t6_ack", ack, 0);
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clock);
      chk("t6_no_cmd", {busy, insns_valid}, 0);
    end
    // randomized traffic
    pr = 50;
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (c % 250 == 0) pr = $urandom_range(0, 100);
      reset = $urandom_range(0, 599) == 0;
      if ($urandom_range(0, 2) == 0) tog = ~tog;
      op = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      w0 = 16'($urandom);
      w1 = 16'($urandom);
      o_bits = 16'($urandom);
      insns_ready = $urandom_range(0, 99) < pr;
      i_ready = $urandom_range(0, 99) < pr;
      o_valid = $urandom_range(0, 99) < pr;
      clr = $urandom_range(0, 31) == 0;
    end
    tick();
    @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
